// File: rtl/repeat_vote_pkg.sv
// Shared types and helpers for the time-redundant vote controller.
package repeat_vote_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic int cnt_width(input int reps);
    return $clog2(reps + 1);
  endfunction

endpackage

// File: rtl/majority_voter.sv
// Per-bit ones counters plus sample counter; vote/unanimous/samples include the sample being taken this cycle.
module majority_voter
  import repeat_vote_pkg::*;
#(
  parameter int N    = 10,
  parameter int REPS = 5,
  localparam int CW  = cnt_width(REPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          sample_en,
  input  logic [N-1:0]  data,
  output logic [N-1:0]  vote,
  output logic          unanimous,
  output logic [CW-1:0] samples
);

  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [CW-1:0] samples_q, samples_d;

  always_comb begin
    samples_d = samples_q;
    for (int b = 0; b < N; b++) cnt_d[b] = cnt_q[b];
    if (clear) begin
      samples_d = '0;
      for (int b = 0; b < N; b++) cnt_d[b] = '0;
    end else if (sample_en) begin
      samples_d = samples_q + 1'b1;
      for (int b = 0; b < N; b++) cnt_d[b] = cnt_q[b] + CW'(data[b]);
    end
  end

  // Strict majority: ties (only possible with an even sample count) give 0.
  always_comb begin
    vote      = '0;
    unanimous = (samples_d != '0);
    for (int b = 0; b < N; b++) begin
      vote[b] = ({cnt_d[b], 1'b0} > {1'b0, samples_d});
      if ((cnt_d[b] != '0) && (cnt_d[b] != samples_d)) unanimous = 1'b0;
    end
  end

  assign samples = samples_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      samples_q <= '0;
      for (int b = 0; b < N; b++) cnt_q[b] <= '0;
    end else begin
      samples_q <= samples_d;
      for (int b = 0; b < N; b++) cnt_q[b] <= cnt_d[b];
    end
  end

endmodule

// File: rtl/repeat_vote_ctrl.sv
// Runs an unreliable datapath REPS times on one held operand pair and returns the bitwise majority.
module repeat_vote_ctrl
  import repeat_vote_pkg::*;
#(
  parameter int N       = 10,
  parameter int REPS    = 5,
  parameter int FLUSH   = 2,
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  output logic [N-1:0] dp_x_o,
  output logic [N-1:0] dp_y_o,
  input  logic [N-1:0] dp_z_i,
  input  logic         dp_valid_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] z_o,
  output logic         unanimous_o,
  output logic         timeout_o
);

  localparam int CW = cnt_width(REPS);
  localparam int FW = (FLUSH > 0) ? $clog2(FLUSH + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state_q, state_d;
  logic [FW-1:0] flush_q;
  logic [TW-1:0] to_q;
  logic          accept, sample_en, last_sample, expire;
  logic [N-1:0]  vote;
  logic          vote_unan;
  logic [CW-1:0] samples;

  assign in_ready_o  = (state_q == S_IDLE) && !reset;
  assign out_valid_o = (state_q == S_DONE);
  assign accept      = in_valid_i && in_ready_o;
  assign sample_en   = (state_q == S_COLLECT) && dp_valid_i;
  assign last_sample = sample_en && (samples == CW'(REPS));
  // Expiry fires on the last of TIMEOUT collect cycles, as the counter reaches 0.
  assign expire      = (state_q == S_COLLECT) && (to_q <= TW'(1));

  majority_voter #(.N(N), .REPS(REPS)) u_voter (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .sample_en (sample_en),
    .data      (dp_z_i),
    .vote      (vote),
    .unanimous (vote_unan),
    .samples   (samples)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = S_FLUSH;
      S_FLUSH:   if (flush_q == '0) state_d = S_COLLECT;
      S_COLLECT: if (last_sample || expire) state_d = S_DONE;
      S_DONE:    if (out_ready_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      flush_q     <= '0;
      to_q        <= '0;
      dp_x_o      <= '0;
      dp_y_o      <= '0;
      z_o         <= '0;
      unanimous_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dp_x_o  <= x_i;
        dp_y_o  <= y_i;
        flush_q <= FW'(FLUSH);
      end else if ((state_q == S_FLUSH) && (flush_q != '0)) begin
        flush_q <= flush_q - 1'b1;
      end
      if ((state_q == S_FLUSH) && (flush_q == '0)) begin
        to_q <= TW'(TIMEOUT);
      end else if ((state_q == S_COLLECT) && (to_q != '0)) begin
        to_q <= to_q - 1'b1;
      end
      // A final sample arriving on the expiry cycle still completes the set normally.
      if ((state_q == S_COLLECT) && (state_d == S_DONE)) begin
        z_o         <= vote;
        unanimous_o <= vote_unan;
        timeout_o   <= !last_sample;
      end
    end
  end

endmodule

// File: tb/tb_repeat_vote_ctrl.sv
// Directed and randomized checks of repeat_vote_ctrl against a sample-list reference model.
module tb_repeat_vote_ctrl;

  localparam int N       = 10;
  localparam int REPS    = 5;
  localparam int FLUSH   = 2;
  localparam int TIMEOUT = 32;
  localparam int PLEN    = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [N-1:0] x_i, y_i;
  logic [N-1:0] dp_x_o, dp_y_o;
  logic [N-1:0] dp_z_i;
  logic         dp_valid_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [N-1:0] z_o;
  logic         unanimous_o;
  logic         timeout_o;

  int nchecks = 0;
  int nerr    = 0;

  // Per-cycle datapath stimulus; index i is sampled at the (i+1)-th edge after accept.
  logic         plan_v [PLEN];
  logic [N-1:0] plan_z [PLEN];

  repeat_vote_ctrl #(.N(N), .REPS(REPS), .FLUSH(FLUSH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_i         (x_i),
    .y_i         (y_i),
    .dp_x_o      (dp_x_o),
    .dp_y_o      (dp_y_o),
    .dp_z_i      (dp_z_i),
    .dp_valid_i  (dp_valid_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .z_o         (z_o),
    .unanimous_o (unanimous_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plan_clear();
    for (int i = 0; i < PLEN; i++) begin
      plan_v[i] = 1'b0;
      plan_z[i] = '0;
    end
  endtask

  // Place samples in the collect window (index FLUSH+1 onwards).
  task automatic plan_collect(input int idx, input logic [N-1:0] z);
    plan_v[FLUSH + 1 + idx] = 1'b1;
    plan_z[FLUSH + 1 + idx] = z;
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                       input int hold);
    int           ones [N];
    int           ns, jend, lat, seen;
    bit           etmo, eu;
    logic [N-1:0] ez, xn;
    // Reference: walk the collect window, gather valid samples until REPS or TIMEOUT cycles.
    ns = 0; etmo = 1'b1; jend = TIMEOUT;
    for (int b = 0; b < N; b++) ones[b] = 0;
    for (int j = 1; j <= TIMEOUT; j++) begin
      if (plan_v[FLUSH + j]) begin
        ns++;
        for (int b = 0; b < N; b++) ones[b] += int'(plan_z[FLUSH + j][b]);
      end
      if (ns == REPS) begin
        etmo = 1'b0;
        jend = j;
        break;
      end
    end
    ez = '0;
    eu = (ns > 0);
    for (int b = 0; b < N; b++) begin
      ez[b] = (2 * ones[b] > ns);
      if (ones[b] != 0 && ones[b] != ns) eu = 1'b0;
    end
    lat = FLUSH + jend;

    chk({tag, "_ready"}, 32'(in_ready_o), 32'd1);
    x_i = x; y_i = y; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk({tag, "_dpx"}, 32'(dp_x_o), 32'(x));
    chk({tag, "_dpy"}, 32'(dp_y_o), 32'(y));

    seen = -1;
    for (int i = 0; i < PLEN - 4 && seen < 0; i++) begin
      dp_valid_i = plan_v[i];
      dp_z_i     = plan_z[i];
      tick();
      if (out_valid_o) seen = i;
    end
    dp_valid_i = 1'b0;
    dp_z_i     = '0;
    chk({tag, "_latency"}, 32'(seen), 32'(lat));
    chk({tag, "_z"}, 32'(z_o), 32'(ez));
    chk({tag, "_unan"}, 32'(unanimous_o), 32'(eu));
    chk({tag, "_tmo"}, 32'(timeout_o), 32'(etmo));

    // Back-pressure: result held, new operands refused.
    xn = ~x;
    for (int h = 0; h < hold; h++) begin
      in_valid_i = 1'b1; x_i = xn; y_i = ~y;
      tick();
      chk({tag, "_hold_valid"}, 32'(out_valid_o), 32'd1);
      chk({tag, "_hold_z"}, 32'(z_o), 32'(ez));
      chk({tag, "_hold_ready"}, 32'(in_ready_o), 32'd0);
      chk({tag, "_hold_dpx"}, 32'(dp_x_o), 32'(x));
    end
    // Handshake edge with in_valid still high must not accept.
    in_valid_i = 1'b1; x_i = xn; out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    chk({tag, "_rel_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_rel_ready"}, 32'(in_ready_o), 32'd1);
    chk({tag, "_rel_dpx"}, 32'(dp_x_o), 32'(x));
  endtask

  initial begin
    logic [N-1:0] rx, ry, base;
    int           p;

    reset = 1'b1; in_valid_i = 1'b0; x_i = '0; y_i = '0;
    dp_z_i = '0; dp_valid_i = 1'b0; out_ready_i = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(in_ready_o), 32'd0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(in_ready_o), 32'd1);
    chk("post_rst_z", 32'(z_o), 32'd0);
    chk("post_rst_flags", 32'({unanimous_o, timeout_o}), 32'd0);
    chk("post_rst_dp", 32'({dp_x_o, dp_y_o}), 32'd0);

    // Clean datapath: z = x^y every cycle.
    plan_clear();
    for (int i = 0; i < PLEN; i++) begin
      plan_v[i] = 1'b1;
      plan_z[i] = 10'h155 ^ 10'h0FF;
    end
    do_op("clean", 10'h155, 10'h0FF, 0);

    plan_clear();
    plan_collect(0, 10'h3FF); plan_collect(1, 10'h3FF); plan_collect(2, 10'h000);
    plan_collect(3, 10'h3FF); plan_collect(4, 10'h000);
    do_op("mixed", 10'h012, 10'h345, 1);

    // Stale results during flush must be discarded.
    plan_clear();
    for (int i = 0; i <= FLUSH; i++) begin
      plan_v[i] = 1'b1;
      plan_z[i] = 10'h3FF;
    end
    for (int k = 0; k < REPS; k++) plan_collect(k, 10'h000);
    do_op("stale", 10'h2AA, 10'h155, 0);

    plan_clear();
    plan_collect(0, 10'h001); plan_collect(1, 10'h001);
    do_op("timeout", 10'h001, 10'h000, 0);

    plan_clear();
    plan_collect(0, 10'h001); plan_collect(3, 10'h000);
    do_op("tie", 10'h0F0, 10'h00F, 10);

    plan_clear();
    plan_collect(TIMEOUT - 1, 10'h077);
    do_op("last_cycle_sample", 10'h111, 10'h222, 0);

    // Reset in COLLECT aborts without emitting a result.
    plan_clear();
    x_i = 10'h3C3; y_i = 10'h0AA; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    for (int i = 0; i < FLUSH + 3; i++) begin
      dp_valid_i = 1'b1; dp_z_i = 10'h3FF;
      tick();
    end
    dp_valid_i = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrst_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_ready", 32'(in_ready_o), 32'd0);
    chk("midrst_z", 32'(z_o), 32'd0);
    chk("midrst_flags", 32'({unanimous_o, timeout_o}), 32'd0);
    chk("midrst_dp", 32'({dp_x_o, dp_y_o}), 32'd0);
    reset = 1'b0;
    tick();
    chk("midrst_idle", 32'(in_ready_o), 32'd1);
    chk("midrst_novalid", 32'(out_valid_o), 32'd0);

    // Randomized operations; p=0 forces a timeout with no samples.
    for (int r = 0; r < 12; r++) begin
      rx = N'($urandom); ry = N'($urandom); base = N'($urandom);
      p = $urandom_range(0, 4);
      plan_clear();
      for (int i = 0; i < PLEN; i++) begin
        plan_v[i] = ($urandom_range(0, 3) < p);
        plan_z[i] = ($urandom_range(0, 2) == 0) ? (base ^ N'($urandom)) : base;
      end
      do_op($sformatf("rand%0d", r), rx, ry, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/repeat_vote_ctrl.md
# repeat_vote_ctrl

Sequencer that wraps the unreliable N-bit `circuit` datapath and runs it under time redundancy. It accepts one operand pair through a valid/ready handshake and holds the operands on the datapath inputs. It discards results still in flight, collects REPS results, and returns their bitwise majority together with quality flags. It sits between the operand source and `circuit`, and it is the only driver of the datapath `x_i`/`y_i`.

## Interface
Parameters:
- N, 10, operand/result width; must match `circuit`.
- REPS, 5, samples voted per operation; odd, 3..15.
- FLUSH, 2, cycles after operand change during which datapath `valid_o` is ignored (datapath latency).
- TIMEOUT, 32, max cycles in COLLECT without completing REPS samples.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid_i  in  1  operand pair offered.
- in_ready_o  out  1  controller can accept operands.
- x_i, y_i  in  N  operands.
- dp_x_o, dp_y_o  out  N  operands to the datapath.
- dp_z_i  in  N  datapath result.
- dp_valid_i  in  1  datapath result valid.
- out_valid_o  out  1  voted result available.
- out_ready_i  in  1  consumer accepts the result.
- z_o  out  N  majority-voted result.
- unanimous_o  out  1  every bit agreed across all REPS samples.
- timeout_o  out  1  operation ended by timeout; z_o is a vote over fewer samples.

## Operation
- States: IDLE, FLUSH, COLLECT, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o: register x_i/y_i into dp_x_o/dp_y_o, clear the vote counters and sample count, load the flush counter with FLUSH, and go to FLUSH.
- FLUSH:
  - Decrement every cycle; dp_valid_i is ignored.
  - At 0, go to COLLECT and load the timeout counter with TIMEOUT.
  - FLUSH=0 goes directly to COLLECT.
- COLLECT:
  - On each cycle with dp_valid_i, every bit counter cnt[b] increments if dp_z_i[b]=1, and the sample count increments.
  - When the sample count reaches REPS, go to DONE.
  - The timeout counter decrements every cycle; at 0 go to DONE with timeout_o=1.
  - If the last sample and the timeout expiry occur in the same cycle, the sample is counted and timeout_o=0.
- Vote:
  - z_o[b] = (cnt[b]*2 > samples).
  - Ties, which can only occur on timeout with an even sample count, resolve to 0.
  - With samples=0, z_o=0 and unanimous_o=0.
  - unanimous_o = for all b, cnt[b]∈{0, samples}, and samples>0.
- DONE:
  - out_valid_o=1; z_o, unanimous_o and timeout_o are registered and stable while out_valid_o=1.
  - On out_ready_i, go to IDLE.
- dp_x_o/dp_y_o hold their value from the last accept until the next accept, including through DONE and IDLE.
- Widths:
  - Counter width CW=$clog2(REPS+1), which equals 4 at REPS=15.
  - The timeout counter is $clog2(TIMEOUT+1) bits wide.
  - Counters never wrap: REPS bounds the sample count, and the sample count bounds cnt[b].

## Timing
- Reset values:
  - state=IDLE.
  - in_ready_o=0 during reset, 1 in the first cycle after reset deasserts.
  - out_valid_o=0, z_o=0, unanimous_o=0, timeout_o=0.
  - dp_x_o=0, dp_y_o=0; all counters 0.
- Reset mid-operation aborts immediately; no result is emitted.
- Accept at edge k:
  - dp_x_o is valid from k+1.
  - COLLECT begins at k+1+FLUSH.
- With dp_valid_i high every cycle, out_valid_o rises at k+1+FLUSH+REPS. The minimum operation length is FLUSH+REPS+1 cycles, plus 1 cycle in DONE.
- in_ready_o is combinational from state only (=state==IDLE); there is no path from in_valid_i to in_ready_o.
- The controller does not accept new operands in the same cycle as the DONE handshake; there is one IDLE cycle between operations.
- dp_valid_i is ignored in IDLE, FLUSH and DONE.

## Structure
- Package repeat_vote_pkg:
  - state enum type (IDLE, FLUSH, COLLECT, DONE).
  - function cnt_width(reps) returning $clog2(reps+1).
- Sub-module majority_voter #(N, REPS):
  - Holds the N bit counters and the sample counter.
  - Inputs: clear, sample_en, data.
  - Outputs: vote, unanimous, samples.
- The FSM, flush and timeout counters, and the output registers stay in repeat_vote_ctrl.

## Test plan
- Clean datapath (FLUSH=2, REPS=5, dp_valid_i always 1, dp_z_i=x^y model), accept x=10'h155, y=10'h0FF:
  - out_valid_o at accept+8, z_o=10'h1AA, unanimous_o=1, timeout_o=0.
- Samples 10'h3FF,10'h3FF,10'h000,10'h3FF,10'h000 in COLLECT:
  - z_o=10'h3FF, unanimous_o=0.
- Stale data: dp_z_i=10'h3FF with valid during FLUSH, then five samples of 10'h000:
  - z_o=10'h000, unanimous_o=1; the flush samples are ignored.
- Timeout (TIMEOUT=32): only 2 valid samples, both 10'h001, then valid low:
  - DONE after 32 COLLECT cycles, timeout_o=1, z_o=10'h001.
- Timeout with one sample 10'h001 and one sample 10'h000:
  - the tie resolves to z_o=10'h000.
- Back-pressure and reset:
  - Hold out_ready_i=0 for 10 cycles: outputs stable, in_ready_o=0, new in_valid_i ignored. Release: IDLE one cycle later.
  - Assert reset in COLLECT: next cycle IDLE with all outputs at reset values.
